i281_fetch_unit: RTL

Instruction fetch stage of the i281 CPU. Holds the program counter, selects one 16-bit word from the two 16-word user-code banks (low bank = PC 0–15, high bank = PC 16–31), and registers it into an instruction register. The register is handed to decode over a valid/ready handshake. Execute redirects it on taken branches and jumps; front-panel run/step inputs gate fetching.

---
 rtl/i281_pkg.sv | 14 +
 rtl/i281_code_mux.sv | 24 ++
 rtl/i281_fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/i281_pkg.sv
// Shared i281 definitions: datapath widths and the fetch-stage state encoding.
package i281_pkg;

  localparam int unsigned I281_PC_W       = 5;
  localparam int unsigned I281_WORD_W     = 16;
  localparam int unsigned I281_BANK_WORDS = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStepPend
  } fetch_state_e;

endpackage

// File: rtl/i281_code_mux.sv
// Combinational 32:1 word select across the two flattened user-code banks.
module i281_code_mux
  import i281_pkg::*;
(
  input  logic [I281_BANK_WORDS*I281_WORD_W-1:0] code_low_i,
  input  logic [I281_BANK_WORDS*I281_WORD_W-1:0] code_high_i,
  input  logic [I281_PC_W-1:0]                   addr_i,
  output logic [I281_WORD_W-1:0]                 word_o
);

  logic [I281_BANK_WORDS*I281_WORD_W-1:0] bank;

  // addr[4] picks the bank, addr[3:0] the word within it
  always_comb begin
    bank   = addr_i[4] ? code_high_i : code_low_i;
    word_o = '0;
    for (int k = 0; k < int'(I281_BANK_WORDS); k++) begin
      if (addr_i[3:0] == k[3:0]) begin
        word_o = bank[k*I281_WORD_W +: I281_WORD_W];
      end
    end
  end

endmodule

// File: rtl/i281_fetch_unit.sv
// i281 instruction fetch: PC, run/step control FSM, instruction register with
// valid/ready handoff to decode, redirect from execute, accepted-instruction count.
module i281_fetch_unit
  import i281_pkg::*;
#(
  parameter logic [I281_PC_W-1:0] RESET_PC = 5'd0
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   run,
  input  logic                                   step,
  input  logic [I281_BANK_WORDS*I281_WORD_W-1:0] code_low,
  input  logic [I281_BANK_WORDS*I281_WORD_W-1:0] code_high,
  input  logic                                   redirect,
  input  logic [I281_PC_W-1:0]                   redirect_base,
  input  logic [7:0]                             redirect_offset,
  input  logic                                   ir_ready,
  output logic                                   ir_valid,
  output logic [I281_WORD_W-1:0]                 ir,
  output logic [I281_PC_W-1:0]                   ir_pc,
  output logic [I281_PC_W-1:0]                   pc,
  output logic [15:0]                            fetch_count
);

  fetch_state_e           state_q, state_d;
  logic                   step_q;
  logic [I281_PC_W-1:0]   pc_q, pc_d;
  logic [I281_WORD_W-1:0] ir_q, ir_d;
  logic [I281_PC_W-1:0]   ir_pc_q, ir_pc_d;
  logic                   ir_valid_q, ir_valid_d;
  logic [15:0]            count_q, count_d;

  logic                   slot_free, fetch_en, do_fetch, accept, step_edge;
  logic [I281_PC_W-1:0]   redirect_target;
  logic [I281_WORD_W-1:0] fetch_word;
  logic                   unused_offset_hi;

  i281_code_mux u_code_mux (
    .code_low_i  (code_low),
    .code_high_i (code_high),
    .addr_i      (pc_q),
    .word_o      (fetch_word)
  );

  // Only the low 5 offset bits matter under mod-32 arithmetic
  assign unused_offset_hi = ^redirect_offset[7:5];

  // Handshake and control qualifiers
  always_comb begin
    slot_free       = ~ir_valid_q | ir_ready;
    accept          = ir_valid_q & ir_ready;
    fetch_en        = (state_q == StRun) || (state_q == StStepPend);
    do_fetch        = slot_free & fetch_en & ~redirect;
    step_edge       = step & ~step_q;
    redirect_target = redirect_base + 5'd1 + redirect_offset[4:0];
  end

  // Next-state for PC, IR, counter and control FSM
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    count_d    = count_q;
    state_d    = state_q;

    if (redirect) begin
      ir_valid_d = 1'b0;
      pc_d       = redirect_target;
    end else if (do_fetch) begin
      ir_d       = fetch_word;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + 5'd1;
    end else if (accept) begin
      ir_valid_d = 1'b0;
    end

    // Counts accepts even in a redirect cycle; saturates
    if (accept && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StRun;
        end else if (step_edge) begin
          state_d = StStepPend;
        end
      end
      StRun: begin
        if (!run) begin
          state_d = StIdle;
        end
      end
      StStepPend: begin
        // A redirect suppresses do_fetch, so the step survives to the new PC
        if (run) begin
          state_d = StRun;
        end else if (do_fetch) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any in-flight instruction at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      step_q     <= 1'b0;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      count_q    <= count_d;
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_count = count_q;

endmodule
